// File: rtl/bram_bus_bridge.sv
// bram_bus_bridge
//
// Bus-side front end for a single-port, read-first block RAM with one-cycle
// read latency. Requests arrive on a valid/ready channel. They are forwarded
// to the RAM pins, and one response per request returns on a valid/ready
// response channel. At most one response is outstanding. Requests outside
// the RAM window never reach the RAM and are answered with resp_err=1 and
// zero data.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_addr            : byte address (low OFF bits ignored)
//   req_write           : 1 = write, 0 = read
//   req_wdata/req_wstrb : write data and byte enables
//   resp_valid/ready    : response handshake
//   resp_rdata          : pre-access word (zero on error)
//   resp_err            : out-of-window access
//   ram_addr/ram_data_w : RAM word address and write data (don't-care when !ram_en)
//   ram_data_r          : RAM read data, one cycle after ram_en, held while !ram_en
//   ram_en/ram_sel      : RAM enable and byte write selects
module bram_bus_bridge #(
  parameter int                ADDR_W    = 14,
  parameter int                DATA_L    = 4,
  parameter int                BUS_AW    = 32,
  parameter logic [BUS_AW-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BUS_AW-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [DATA_L*8-1:0]   req_wdata,
  input  logic [DATA_L-1:0]     req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_L*8-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_L*8-1:0]   ram_data_w,
  input  logic [DATA_L*8-1:0]   ram_data_r,
  output logic                  ram_en,
  output logic [DATA_L-1:0]     ram_sel
);

  localparam int DATA_W = DATA_L * 8;
  localparam int OFF    = $clog2(DATA_L);
  localparam int WIN_LO = ADDR_W + OFF;

  logic pending_q, pending_d;
  logic pend_err_q, pend_err_d;
  logic acc;
  logic hit;
  logic unused_addr_lsb;

  // The byte offset inside a word carries no information for the RAM.
  assign unused_addr_lsb = ^req_addr[OFF-1:0];

  // Ready depends only on our state and resp_ready, never on req_valid:
  // a slot is free when nothing is pending or the pending response leaves
  // this cycle.
  assign req_ready = ~pending_q | resp_ready;
  assign acc       = req_valid & req_ready;
  assign hit       = (req_addr[BUS_AW-1:WIN_LO] == BASE_ADDR[BUS_AW-1:WIN_LO]);

  // Gating the enable with rst ensures a reset cycle leaves no RAM side effect.
  assign ram_en     = acc & hit & ~rst;
  assign ram_sel    = (req_write & ram_en) ? req_wstrb : '0;
  assign ram_addr   = req_addr[WIN_LO-1:OFF];
  assign ram_data_w = req_wdata;

  // The RAM output is held while ram_en=0, so resp_rdata stays stable across
  // a stall without a local data register.
  assign resp_valid = pending_q;
  assign resp_err   = pend_err_q;
  assign resp_rdata = pend_err_q ? {DATA_W{1'b0}} : ram_data_r;

  always_comb begin
    pending_d  = pending_q;
    pend_err_d = pend_err_q;
    if (acc) begin
      // This also covers a response leaving and a new request arriving in
      // the same cycle: the slot stays occupied.
      pending_d  = 1'b1;
      pend_err_d = ~hit;
    end else if (pending_q & resp_ready) begin
      pending_d  = 1'b0;
    end
  end

  // Response slot register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      pend_err_q <= pend_err_d;
    end
  end

endmodule

// File: doc/bram_bus_bridge.md
# bram_bus_bridge

Bus-side front end for the single-port block RAM. It accepts valid/ready memory requests from the core's load/store or fetch path, drives the RAM's address, enable and byte-select pins, and returns one response per request on a valid/ready response channel. It absorbs the RAM's one-cycle read latency and response back-pressure without losing data. Requests whose address falls outside the RAM window are not forwarded to the RAM and get an error response.

## Interface
- `ADDR_W`, 14: RAM word-address width; must match the attached RAM.
- `DATA_L`, 4: bytes per word; power of two. `DATA_W = DATA_L*8`; `OFF = log2(DATA_L)`.
- `BUS_AW`, 32: bus byte-address width.
- `BASE_ADDR`, 32'h0000_0000: window base; aligned to `2^(ADDR_W+OFF)`.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_addr` in BUS_AW: byte address. Low `OFF` bits are ignored.
- `req_write` in 1: 1 selects write, 0 selects read.
- `req_wdata` in DATA_W: write data.
- `req_wstrb` in DATA_L: byte enables; used only when `req_write`=1.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed when high together with `resp_valid`.
- `resp_rdata` out DATA_W: word read.
- `resp_err` out 1: out-of-window access.
- `ram_addr` out ADDR_W: `req_addr[ADDR_W+OFF-1:OFF]`.
- `ram_data_w` out DATA_W: `req_wdata`.
- `ram_data_r` in DATA_W: RAM read port (one-cycle latency; holds while `ram_en`=0).
- `ram_en` out 1: RAM enable.
- `ram_sel` out DATA_L: byte write selects.

## Operation
- State: `pending` (a response is outstanding) and `pend_err`.
- Accept condition: `acc = req_valid & req_ready`.
- `req_ready = ~pending | resp_ready`. This is combinational from `resp_ready`; there is no combinational path from `req_valid` to `req_ready`.
- Window check: `hit = (req_addr[BUS_AW-1:ADDR_W+OFF] == BASE_ADDR[BUS_AW-1:ADDR_W+OFF])`.
- RAM enable: `ram_en = acc & hit & ~rst`.
- Byte selects: `ram_sel = (req_write & ram_en) ? req_wstrb : 0`.
- The RAM is read-first: every enabled access, read or write, returns the pre-write word.
- Pending update each cycle:
  - If `acc`: `pending`←1 and `pend_err`←`~hit`.
  - Else if `resp_valid & resp_ready`: `pending`←0.
  - Otherwise both hold.
- Response outputs:
  - `resp_valid = pending`.
  - `resp_err = pend_err`.
  - `resp_rdata = pend_err ? 0 : ram_data_r`.
  - A write response carries the old word.
- Stall: while `pending` and `~resp_ready`, `ram_en`=0. The RAM output therefore holds and `resp_rdata` stays stable, as the valid/ready rules require.
- Simultaneous response handshake and new accept in one cycle: `pending` stays 1 and the new request's data appears the next cycle.
- Out-of-window write: no RAM access and no side effect.
- Reset in any state clears `pending`. An in-flight response is dropped, and a RAM access issued before reset is not reported.

## Timing
- Reset values: `req_ready`=1 after reset; `resp_valid`=0; `resp_err`=0; `ram_en`=0; `ram_sel`=0.
- Latency: accept at cycle N gives `resp_valid`=1 at N+1.
- Throughput: one request per cycle while `resp_ready` stays high.
- At most one response is outstanding; there is no internal queue.
- `ram_addr` and `ram_data_w` are combinational from the request and are don't-care when `ram_en`=0.
- `resp_rdata` is valid only while `resp_valid`=1.

## Test plan
- **Write then read:** write 32'hDEADBEEF, `wstrb`=4'hF, addr 0x40; then read 0x40. The write response must carry the prior word with `resp_err`=0. The read response at N+1 must be 32'hDEADBEEF.
- **Partial write:** after word 0x40 = 32'hDEADBEEF, write 32'h0000_1200 with `wstrb`=4'b0010. A following read of 0x40 must return 32'hDEAD12EF.
- **Back-to-back reads:** read 0x0, 0x4 and 0x8 on consecutive cycles with `resp_ready`=1. Responses must appear on three consecutive cycles in order, and `req_ready` must stay 1 throughout.
- **Back-pressure:** read 0x40, then hold `resp_ready`=0 for 5 cycles with a second request valid. `req_ready`=0 and `ram_en`=0 for all 5 cycles, and `resp_rdata` stays stable. The second response follows one cycle after release.
- **Out of window:** with `ADDR_W`=14, `BASE_ADDR`=0, read 0x0001_0000. Expect `ram_en`=0, `resp_err`=1, `resp_rdata`=0. A write to the same address leaves RAM contents unchanged.
- **Reset mid-stall:** with a response pending and `resp_ready`=0, assert `rst` for one cycle. The next cycle has `resp_valid`=0 and `req_ready`=1, and no stale response appears afterwards.
